sub512_seq: RTL

- Multi-cycle 512-bit subtractor/comparator: computes A - B one CHUNK-wide slice per cycle, propagating borrow LSB to MSB.
- Companion to the registered 512-bit CLA adder in the MAC datapath. Provides the inverse operation and magnitude compare for accumulator correction and modular reduction.
- Uses a valid/ready handshake on both sides.
- Shares the global clock enable `en` with the adder block.

---
 rtl/mac512_pkg.sv | 21 ++
 rtl/sub512_seq_sub_chunk.sv | 22 ++
 rtl/sub512_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mac512_pkg.sv
// Shared definitions for the 512-bit MAC datapath blocks: default widths,
// the sequential subtractor state encoding and an index-width helper.
package mac512_pkg;

    localparam int WIDTH_DEF  = 512;
    localparam int CHUNK_DEF  = 64;
    localparam int NCHUNK_DEF = WIDTH_DEF / CHUNK_DEF;
    localparam int IDX_W_DEF  = $clog2(NCHUNK_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_t;

    // Width of a chunk index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub512_seq_sub_chunk.sv
// sub_chunk: combinational CHUNK-bit subtract with borrow in and borrow out.
// The result is computed in CHUNK+1 bits so the top bit is the borrow.
module sub_chunk #(
    parameter int CHUNK = 64
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             borrow_in,
    output logic [CHUNK-1:0] diff,
    output logic             borrow_out
);

    logic [CHUNK:0] full;

    // Extended subtraction; a borrow shows up as a set MSB.
    always_comb begin
        full       = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, borrow_in};
        diff       = full[CHUNK-1:0];
        borrow_out = full[CHUNK];
    end

endmodule

// File: rtl/sub512_seq.sv
// sub512_seq: multi-cycle WIDTH-bit subtractor / magnitude comparator.
// One CHUNK-wide slice of A - B is computed per enabled cycle, LSB first,
// through a single time-multiplexed sub_chunk instance.
// Optional macro SUB_SIGNED_FLAGS_EN adds signed less-than and signed
// overflow flags; without it s_lt and ovf are tied low.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for operands, in_ready high
//   ST_RUN  | subtracting one slice per enabled edge, idx = slice
//   ST_DONE | result and flags stable, out_valid high until out_ready
module sub512_seq
    import mac512_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             borrow_out,
    output logic             zero,
    output logic             s_lt,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    sub_state_t       state_q;
    sub_state_t       state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx_q;
    logic             borrow_q;
    logic             nz_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_out_q;
    logic             zero_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] diff;
    logic             borrow_nxt;
    logic             last;

    // Select the operand slices addressed by the current chunk index.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .a          (a_chunk),
        .b          (b_chunk),
        .borrow_in  (borrow_q),
        .diff       (diff),
        .borrow_out (borrow_nxt)
    );

    assign last = (idx_q == IDX_LAST);

    // State register; en low freezes the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, slice-by-slice result build and final flag capture.
    // Flags only change on the last slice so they hold through RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            borrow_q     <= 1'b0;
            nz_q         <= 1'b0;
            res_q        <= '0;
            borrow_out_q <= 1'b0;
            zero_q       <= 1'b0;
        end else if (en) begin
            if (state_q == ST_IDLE && in_valid) begin
                a_q      <= A_in;
                b_q      <= B_in;
                idx_q    <= '0;
                borrow_q <= 1'b0;
                nz_q     <= 1'b0;
            end
            if (state_q == ST_RUN) begin
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        res_q[i*CHUNK +: CHUNK] <= diff;
                    end
                end
                borrow_q <= borrow_nxt;
                nz_q     <= nz_q | (|diff);
                idx_q    <= idx_q + IDX_W'(1);
                if (last) begin
                    borrow_out_q <= borrow_nxt;
                    zero_q       <= ~(nz_q | (|diff));
                end
            end
        end
    end

    assign res        = res_q;
    assign borrow_out = borrow_out_q;
    assign zero       = zero_q;

`ifdef SUB_SIGNED_FLAGS_EN
    logic a_s;
    logic b_s;
    logic r_s;
    logic ovf_nxt;
    logic s_lt_q;
    logic ovf_q;

    // In the last RUN cycle the selected slices are the top ones, so their
    // MSBs are the operand and result sign bits.
    assign a_s     = a_chunk[CHUNK-1];
    assign b_s     = b_chunk[CHUNK-1];
    assign r_s     = diff[CHUNK-1];
    assign ovf_nxt = (a_s ^ b_s) & (r_s ^ a_s);

    // Signed flags captured together with the final slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_lt_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en && state_q == ST_RUN && last) begin
            ovf_q  <= ovf_nxt;
            s_lt_q <= r_s ^ ovf_nxt;
        end
    end

    assign s_lt = s_lt_q;
    assign ovf  = ovf_q;
`else
    assign s_lt = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule
